// File: rtl/npu_wb_sequencer.sv
// Write-back sequencer: buffers NPU result words and writes them to consecutive
// data-memory addresses, publishing the active write address to the hazard unit.
module npu_wb_sequencer #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  num_words,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready,
    input  logic              mem_gnt,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_is_writing,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              en_npu,
    output logic              done,
    output logic [1:0]        dbg_state
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  acc_cnt;
    logic [LEN_W-1:0]  wr_cnt;

    logic [DATA_W-1:0] fifo_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  fifo_count;

    logic push;
    logic pop;

    // Valid/ready: a result word transfers on a rising edge where res_valid && res_ready.
    // res_ready depends on registered state only, so the NPU may use it to form res_valid.
    assign res_ready = (state == RUN) && (fifo_count < CNT_W'(DEPTH)) && (acc_cnt < len_q);
    assign push      = res_valid && res_ready;
    assign pop       = (state == RUN) && (fifo_count != '0) && mem_gnt;

    assign en_npu    = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            acc_cnt <= '0;
            wr_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        len_q   <= num_words;
                        acc_cnt <= '0;
                        wr_cnt  <= '0;
                        state   <= (num_words == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (push) acc_cnt <= acc_cnt + LEN_W'(1);
                    if (pop)  wr_cnt  <= wr_cnt + LEN_W'(1);
                    // Leave one cycle after the last write so done follows the final strobe.
                    if (wr_cnt == len_q) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= res_data;
    end

    // Address and data hold their last values between writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_wr         <= 1'b0;
            mem_is_writing <= '0;
            mem_wdata      <= '0;
        end else begin
            mem_wr <= pop;
            if (pop) begin
                mem_is_writing <= base_q + ADDR_W'(wr_cnt);
                mem_wdata      <= fifo_mem[rd_ptr];
            end
        end
    end

endmodule

// File: tb/tb_npu_wb_sequencer.sv
// Bench for npu_wb_sequencer: queue-based job model compared every cycle,
// directed scenarios with literal expectations, then randomized jobs.
module tb_npu_wb_sequencer;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int LEN_W  = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [LEN_W-1:0]  num_words;
    logic              res_valid;
    logic [DATA_W-1:0] res_data;
    logic              res_ready;
    logic              mem_gnt;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_is_writing;
    logic [DATA_W-1:0] mem_wdata;
    logic              en_npu;
    logic              done;
    logic [1:0]        dbg_state;

    npu_wb_sequencer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .num_words(num_words), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .mem_gnt(mem_gnt), .mem_wr(mem_wr),
        .mem_is_writing(mem_is_writing), .mem_wdata(mem_wdata),
        .en_npu(en_npu), .done(done), .dbg_state(dbg_state)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural job model
    bit                m_active;
    bit                m_done;
    logic [DATA_W-1:0] m_fifo[$];
    int                m_len, m_base, m_acc, m_wr;
    bit                m_mem_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;

    // Observation log and NPU feed
    logic [ADDR_W-1:0] obs_addr[$];
    logic [DATA_W-1:0] obs_data[$];
    logic [DATA_W-1:0] feed_q[$];
    logic [DATA_W-1:0] exp_q[$];
    int first_wr_cyc, last_wr_cyc, done_cyc, first_acc_cyc, acc_obs, start_cyc;
    bit vrand = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_ready();
        return m_active && (m_fifo.size() < DEPTH) && (m_acc < m_len);
    endfunction

    task automatic model_reset();
        m_active = 1'b0;
        m_done   = 1'b0;
        m_fifo.delete();
        m_len = 0; m_base = 0; m_acc = 0; m_wr = 0;
        m_mem_wr = 1'b0;
        m_addr   = '0;
        m_wdata  = '0;
    endtask

    task automatic model_step(input bit st, input int base, input int nw, input bit v,
                              input logic [DATA_W-1:0] d, input bit g);
        bit rdy;
        rdy = model_ready();
        if (m_done) begin
            m_done   = 1'b0;
            m_mem_wr = 1'b0;
        end else if (!m_active) begin
            m_mem_wr = 1'b0;
            if (st) begin
                m_base = base; m_len = nw; m_acc = 0; m_wr = 0;
                if (nw == 0) m_done = 1'b1;
                else         m_active = 1'b1;
            end
        end else if (m_wr == m_len) begin
            m_active = 1'b0;
            m_done   = 1'b1;
            m_mem_wr = 1'b0;
        end else begin
            if (m_fifo.size() > 0 && g) begin
                m_mem_wr = 1'b1;
                m_addr   = ADDR_W'((m_base + m_wr) % (1 << ADDR_W));
                m_wdata  = m_fifo.pop_front();
                m_wr++;
            end else begin
                m_mem_wr = 1'b0;
            end
            if (v && rdy) begin
                m_fifo.push_back(d);
                m_acc++;
            end
        end
    endtask

    task automatic check_outputs();
        chk("mem_wr", mem_wr, m_mem_wr);
        chk("mem_is_writing", mem_is_writing, m_addr);
        chk("mem_wdata", mem_wdata, m_wdata);
        chk("en_npu", en_npu, m_active);
        chk("done", done, m_done);
        chk("res_ready", res_ready, model_ready());
        if (mem_wr) begin
            obs_addr.push_back(mem_is_writing);
            obs_data.push_back(mem_wdata);
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
        end
        if (done) done_cyc = cyc;
    endtask

    // Driver: one clock cycle; compare at negedge, then drive the next inputs
    task automatic cycle(input bit st, input int base, input int nw, input bit g);
        @(negedge clk);
        cyc++;
        check_outputs();
        start     = st;
        base_addr = ADDR_W'(base);
        num_words = LEN_W'(nw);
        mem_gnt   = g;
        res_valid = (feed_q.size() > 0) && (!vrand || $urandom_range(0, 3) != 0);
        res_data  = res_valid ? feed_q[0] : $urandom();
        if (res_valid && res_ready) begin
            void'(feed_q.pop_front());
            acc_obs++;
            if (first_acc_cyc < 0) first_acc_cyc = cyc;
        end
        model_step(st, base, nw, res_valid, res_data, g);
    endtask

    task automatic run_until_idle(input bit rand_gnt, input bit stray, input int budget);
        bit fin;
        bit g;
        bit st;
        fin = 1'b0;
        for (int i = 0; i < budget; i++) begin
            g  = rand_gnt ? ($urandom_range(0, 3) != 0) : 1'b1;
            st = stray && ($urandom_range(0, 7) == 0);
            cycle(st, int'($urandom_range(0, 1023)), int'($urandom_range(0, 31)), g);
            if (!m_active && !m_done) begin
                fin = 1'b1;
                break;
            end
        end
        if (!fin) begin
            n_checks++;
            n_fail++;
            $display("FAIL job_timeout: job still active after %0d cycles", budget);
        end
    endtask

    task automatic clear_obs();
        obs_addr.delete();
        obs_data.delete();
        first_wr_cyc = -1; last_wr_cyc = -1; done_cyc = -1; first_acc_cyc = -1;
        acc_obs = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
        res_valid = 1'b0; res_data = '0; mem_gnt = 1'b0;
        model_reset();
        clear_obs();
        @(negedge clk);
        @(negedge clk);
        chk("reset_mem_wr", mem_wr, 0);
        chk("reset_addr", mem_is_writing, 0);
        chk("reset_wdata", mem_wdata, 0);
        chk("reset_en_npu", en_npu, 0);
        chk("reset_done", done, 0);
        chk("reset_res_ready", res_ready, 0);
        rst = 1'b0;

        // 1: basic three-word job
        clear_obs();
        feed_q = '{32'hA, 32'hB, 32'hC};
        cycle(1'b1, 'h010, 3, 1'b1);
        run_until_idle(1'b0, 1'b0, 50);
        chk("t1_nwrites", obs_addr.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_addr", obs_addr[i], 'h010 + i);
            chk("t1_data", obs_data[i], 'hA + i);
        end
        chk("t1_latency", first_wr_cyc - first_acc_cyc, 2);
        chk("t1_done_after_last", done_cyc - last_wr_cyc, 1);
        chk("t1_back_to_back", last_wr_cyc - first_wr_cyc, 2);

        // 2: grant withheld, FIFO fills to depth
        clear_obs();
        exp_q.delete();
        for (int i = 0; i < 6; i++) exp_q.push_back($urandom());
        feed_q = exp_q;
        cycle(1'b1, 'h100, 6, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 0, 0, 1'b0);
        chk("t2_acc_during_stall", acc_obs, 4);
        chk("t2_ready_when_full", res_ready, 0);
        chk("t2_no_write_stalled", obs_addr.size(), 0);
        run_until_idle(1'b0, 1'b0, 60);
        chk("t2_nwrites", obs_addr.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk("t2_addr", obs_addr[i], 'h100 + i);
            chk("t2_data", obs_data[i], exp_q[i]);
        end

        // 3: address wrap
        clear_obs();
        feed_q = '{32'h31, 32'h32, 32'h33, 32'h34};
        cycle(1'b1, 'h3FE, 4, 1'b1);
        run_until_idle(1'b0, 1'b0, 50);
        chk("t3_nwrites", obs_addr.size(), 4);
        chk("t3_addr0", obs_addr[0], 'h3FE);
        chk("t3_addr1", obs_addr[1], 'h3FF);
        chk("t3_addr2", obs_addr[2], 'h000);
        chk("t3_addr3", obs_addr[3], 'h001);

        // 4: zero-length job
        clear_obs();
        feed_q = '{32'h41, 32'h42};
        cycle(1'b1, 'h055, 0, 1'b1);
        start_cyc = cyc;
        cycle(1'b0, 0, 0, 1'b1);
        cycle(1'b0, 0, 0, 1'b1);
        cycle(1'b0, 0, 0, 1'b1);
        chk("t4_done_cycle", done_cyc - start_cyc, 1);
        chk("t4_no_writes", obs_addr.size(), 0);
        chk("t4_no_accept", acc_obs, 0);
        feed_q.delete();

        // 5: asynchronous reset mid-job, then stray start during RUN
        clear_obs();
        feed_q = '{32'h51, 32'h52, 32'h53, 32'h54, 32'h55};
        cycle(1'b1, 'h200, 5, 1'b1);
        for (int i = 0; i < 20 && obs_addr.size() < 2; i++) cycle(1'b0, 0, 0, 1'b1);
        chk("t5_two_writes", obs_addr.size(), 2);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_mem_wr", mem_wr, 0);
        chk("t5_rst_addr", mem_is_writing, 0);
        chk("t5_rst_wdata", mem_wdata, 0);
        chk("t5_rst_en_npu", en_npu, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_res_ready", res_ready, 0);
        model_reset();
        feed_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_obs();
        feed_q = '{32'h5A, 32'h5B, 32'h5C};
        for (int i = 0; i < 5; i++) cycle(1'b0, 0, 0, 1'b1);
        chk("t5_no_write_after_rst", obs_addr.size(), 0);
        chk("t5_no_accept_after_rst", acc_obs, 0);
        feed_q.delete();
        clear_obs();
        feed_q = '{32'h11, 32'h22};
        cycle(1'b1, 'h300, 2, 1'b1);
        cycle(1'b1, 'h0AA, 7, 1'b1);
        run_until_idle(1'b0, 1'b0, 50);
        chk("t5_nwrites", obs_addr.size(), 2);
        chk("t5_addr0", obs_addr[0], 'h300);
        chk("t5_addr1", obs_addr[1], 'h301);
        chk("t5_data1", obs_data[1], 'h22);

        // 6: surplus NPU words are refused
        clear_obs();
        feed_q = '{32'h61, 32'h62, 32'h63, 32'h64, 32'h65};
        cycle(1'b1, 'h020, 3, 1'b1);
        run_until_idle(1'b0, 1'b0, 50);
        chk("t6_accepted", acc_obs, 3);
        chk("t6_left_in_npu", feed_q.size(), 2);
        chk("t6_nwrites", obs_addr.size(), 3);
        chk("t6_data2", obs_data[2], 'h63);
        feed_q.delete();

        // Randomized jobs: random lengths, gaps, grant stalls and stray starts
        vrand = 1'b1;
        for (int j = 0; j < 25; j++) begin
            int nw;
            int base;
            int gap;
            clear_obs();
            nw   = int'($urandom_range(0, 12));
            base = int'($urandom_range(0, 1023));
            for (int i = 0; i < nw + int'($urandom_range(0, 3)); i++) feed_q.push_back($urandom());
            gap = int'($urandom_range(0, 2));
            for (int i = 0; i < gap; i++) cycle(1'b0, 0, 0, $urandom_range(0, 1) == 1);
            cycle(1'b1, base, nw, $urandom_range(0, 1) == 1);
            run_until_idle(1'b1, 1'b1, 500);
            chk("rand_nwrites", obs_addr.size(), nw);
            if (nw > 0) chk("rand_last_addr", obs_addr[obs_addr.size() - 1], (base + nw - 1) % 1024);
            feed_q.delete();
        end
        vrand = 1'b0;
        cycle(1'b0, 0, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
